// File: rtl/fp_addsub.sv
// fp_addsub: pipelined IEEE-754 adder/subtractor with round-to-nearest-even.
// The result appears a fixed 5 cycles after the operands are accepted, and one
// operation can be accepted every cycle. Denormal inputs are treated as zero,
// and results that would be denormal are flushed to zero.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   start      operands valid this cycle (no back-pressure)
//   sub        0: op_a + op_b, 1: op_a - op_b
//   op_a/op_b  DATA_W-bit operands
//   done       res and flags valid this cycle
//   res        result; holds its last value while done=0
//   overflow   finite operands rounded to +/-inf
//   underflow  nonzero exact result flushed to +/-0
//   invalid    NaN operand or inf - inf
//   exception  overflow | underflow | invalid
module fp_addsub #(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sub,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              done,
  output logic [DATA_W-1:0] res,
  output logic              overflow,
  output logic              underflow,
  output logic              invalid,
  output logic              exception
);
  localparam int FRAC_W = DATA_W - EXP_W - 1;
  localparam int SIG_W  = FRAC_W + 1;        // significand with hidden bit
  localparam int EXT_W  = SIG_W + 3;         // significand + guard/round/sticky
  localparam int LZ_W   = $clog2(EXT_W + 1);
  localparam int EW     = EXP_W + 2;         // signed working exponent
  localparam int BYP_W  = DATA_W + 2;        // {special, invalid, result}
  localparam logic [EXP_W-1:0]     SHIFT_LIM = EXP_W'(FRAC_W + 3);
  localparam logic signed [EW-1:0] EXP_ONES  = {2'b00, {EXP_W{1'b1}}};
  localparam logic signed [EW-1:0] EXP_ZERO  = {EW{1'b0}};
  localparam logic signed [EW-1:0] EXP_ONE   = {{(EW-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0]    QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  // Leading-zero count of the unnormalised sum; the highest set bit wins.
  function automatic logic [LZ_W-1:0] lzc_f(input logic [EXT_W-1:0] v);
    logic [LZ_W-1:0] cnt;
    cnt = LZ_W'(EXT_W);
    for (int i = 0; i < EXT_W; i++) begin
      if (v[i]) cnt = LZ_W'(EXT_W - 1 - i);
    end
    return cnt;
  endfunction

  // Stage 1: unpack and swap
  logic                 sa, sbe, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
  logic [EXP_W-1:0]     ea, eb;
  logic [FRAC_W-1:0]    fa, fb;
  logic                 s1_vld_d, s1_vld_q, s1_sign_d, s1_sign_q, s1_esub_d, s1_esub_q;
  logic [BYP_W-1:0]     s1_byp_d, s1_byp_q;
  logic [EXP_W-1:0]     s1_exp_big_d, s1_exp_big_q, s1_exp_sml_d, s1_exp_sml_q;
  logic [SIG_W-1:0]     s1_sig_big_d, s1_sig_big_q, s1_sig_sml_d, s1_sig_sml_q;
  // Stage 2: align
  logic [EXP_W-1:0]     diff;
  logic [2*SIG_W+1:0]   shift_buf;
  logic                 s2_vld_d, s2_vld_q, s2_sign_d, s2_sign_q, s2_esub_d, s2_esub_q;
  logic [BYP_W-1:0]     s2_byp_d, s2_byp_q;
  logic [EXP_W-1:0]     s2_exp_d, s2_exp_q;
  logic [SIG_W-1:0]     s2_sig_d, s2_sig_q;
  logic [EXT_W-1:0]     s2_bal_d, s2_bal_q;
  // Stage 3: add/subtract
  logic [EXT_W:0]       a_ext, b_ext;
  logic                 s3_vld_d, s3_vld_q, s3_sign_d, s3_sign_q;
  logic [BYP_W-1:0]     s3_byp_d, s3_byp_q;
  logic [EXP_W-1:0]     s3_exp_d, s3_exp_q;
  logic [EXT_W:0]       s3_sum_d, s3_sum_q;
  // Stage 4: normalise
  logic [LZ_W-1:0]      lz;
  logic [EXT_W-1:0]     norm;
  logic                 s4_vld_d, s4_vld_q, s4_sign_d, s4_sign_q, s4_zero_d, s4_zero_q;
  logic [BYP_W-1:0]     s4_byp_d, s4_byp_q;
  logic signed [EW-1:0] s4_exp_d, s4_exp_q;
  logic [SIG_W-1:0]     s4_man_d, s4_man_q;
  logic [2:0]           s4_grs_d, s4_grs_q;
  // Stage 5: round
  logic                 rnd_up;
  logic [SIG_W:0]       man_rnd;
  logic                 s5_vld_d, s5_vld_q, s5_sign_d, s5_sign_q, s5_zero_d, s5_zero_q;
  logic [BYP_W-1:0]     s5_byp_d, s5_byp_q;
  logic signed [EW-1:0] s5_exp_d, s5_exp_q;
  logic [FRAC_W-1:0]    s5_frac_d, s5_frac_q;
  // Output pack
  logic                 done_d, done_q, ovf_d, ovf_q, unf_d, unf_q, inv_d, inv_q, exc_d, exc_q;
  logic [DATA_W-1:0]    res_d, res_q;

  // Unpack operands, classify specials into the bypass, order by magnitude.
  always_comb begin
    sa     = op_a[DATA_W-1];
    sbe    = op_b[DATA_W-1] ^ sub;
    ea     = op_a[DATA_W-2:FRAC_W];
    eb     = op_b[DATA_W-2:FRAC_W];
    fa     = op_a[FRAC_W-1:0];
    fb     = op_b[FRAC_W-1:0];
    a_zero = (ea == {EXP_W{1'b0}});
    b_zero = (eb == {EXP_W{1'b0}});
    a_inf  = (ea == {EXP_W{1'b1}}) && (fa == {FRAC_W{1'b0}});
    b_inf  = (eb == {EXP_W{1'b1}}) && (fb == {FRAC_W{1'b0}});
    a_nan  = (ea == {EXP_W{1'b1}}) && (fa != {FRAC_W{1'b0}});
    b_nan  = (eb == {EXP_W{1'b1}}) && (fb != {FRAC_W{1'b0}});
    // Ties keep op_a as the larger operand.
    a_big  = (op_a[DATA_W-2:0] >= op_b[DATA_W-2:0]);
    s1_vld_d  = start;
    s1_esub_d = sa ^ sbe;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sbe))) begin
      s1_byp_d = {1'b1, 1'b1, QNAN};
    end else if (a_inf) begin
      s1_byp_d = {2'b10, op_a};
    end else if (b_inf) begin
      s1_byp_d = {2'b10, sbe, op_b[DATA_W-2:0]};
    end else if (a_zero && b_zero) begin
      s1_byp_d = {2'b10, sa & sbe, {(DATA_W-1){1'b0}}};
    end else if (a_zero) begin
      s1_byp_d = {2'b10, sbe, op_b[DATA_W-2:0]};
    end else if (b_zero) begin
      s1_byp_d = {2'b10, op_a};
    end else begin
      s1_byp_d = {2'b00, {DATA_W{1'b0}}};
    end
    if (a_big) begin
      s1_sign_d    = sa;
      s1_exp_big_d = ea;
      s1_exp_sml_d = eb;
      s1_sig_big_d = {1'b1, fa};
      s1_sig_sml_d = {1'b1, fb};
    end else begin
      s1_sign_d    = sbe;
      s1_exp_big_d = eb;
      s1_exp_sml_d = ea;
      s1_sig_big_d = {1'b1, fb};
      s1_sig_sml_d = {1'b1, fa};
    end
  end

  // Align the smaller significand, keeping guard, round and sticky.
  always_comb begin
    diff      = s1_exp_big_q - s1_exp_sml_q;
    shift_buf = {s1_sig_sml_q, 2'b00, {SIG_W{1'b0}}} >> diff;
    if (diff >= SHIFT_LIM) begin
      // Entirely below the round bit: only its presence matters.
      s2_bal_d = {{(SIG_W+2){1'b0}}, 1'b1};
    end else begin
      s2_bal_d = {shift_buf[2*SIG_W+1:SIG_W], |shift_buf[SIG_W-1:0]};
    end
    s2_vld_d  = s1_vld_q;
    s2_byp_d  = s1_byp_q;
    s2_sign_d = s1_sign_q;
    s2_esub_d = s1_esub_q;
    s2_exp_d  = s1_exp_big_q;
    s2_sig_d  = s1_sig_big_q;
  end

  // Magnitude add or subtract; the larger operand keeps the result non-negative.
  always_comb begin
    a_ext = {1'b0, s2_sig_q, 3'b000};
    b_ext = {1'b0, s2_bal_q};
    if (s2_esub_q) begin
      s3_sum_d = a_ext - b_ext;
    end else begin
      s3_sum_d = a_ext + b_ext;
    end
    s3_vld_d  = s2_vld_q;
    s3_byp_d  = s2_byp_q;
    s3_sign_d = s2_sign_q;
    s3_exp_d  = s2_exp_q;
  end

  // Normalise: right by one on carry-out, otherwise left by the leading-zero count.
  always_comb begin
    lz        = lzc_f(s3_sum_q[EXT_W-1:0]);
    norm      = s3_sum_q[EXT_W-1:0] << lz;
    s4_zero_d = (s3_sum_q == {(EXT_W+1){1'b0}});
    if (s3_sum_q[EXT_W]) begin
      s4_man_d = s3_sum_q[EXT_W:4];
      s4_grs_d = {s3_sum_q[3], s3_sum_q[2], s3_sum_q[1] | s3_sum_q[0]};
      s4_exp_d = {2'b00, s3_exp_q} + EXP_ONE;
    end else begin
      s4_man_d = norm[EXT_W-1:3];
      s4_grs_d = norm[2:0];
      s4_exp_d = {2'b00, s3_exp_q} - {{(EW-LZ_W){1'b0}}, lz};
    end
    s4_vld_d  = s3_vld_q;
    s4_byp_d  = s3_byp_q;
    s4_sign_d = s3_sign_q;
  end

  // Round to nearest, ties to even; a carry-out bumps the exponent.
  always_comb begin
    rnd_up  = s4_grs_q[2] & (s4_grs_q[1] | s4_grs_q[0] | s4_man_q[0]);
    man_rnd = {1'b0, s4_man_q} + {{SIG_W{1'b0}}, rnd_up};
    if (man_rnd[SIG_W]) begin
      s5_frac_d = man_rnd[FRAC_W:1];
      s5_exp_d  = s4_exp_q + EXP_ONE;
    end else begin
      s5_frac_d = man_rnd[FRAC_W-1:0];
      s5_exp_d  = s4_exp_q;
    end
    s5_vld_d  = s4_vld_q;
    s5_byp_d  = s4_byp_q;
    s5_sign_d = s4_sign_q;
    s5_zero_d = s4_zero_q;
  end

  // Pack the result; specials override the datapath, flags only with done.
  always_comb begin
    ovf_d = 1'b0;
    unf_d = 1'b0;
    inv_d = 1'b0;
    if (s5_vld_q) begin
      done_d = 1'b1;
      if (s5_byp_q[BYP_W-1]) begin
        res_d = s5_byp_q[DATA_W-1:0];
        inv_d = s5_byp_q[DATA_W];
      end else if (s5_zero_q) begin
        res_d = {DATA_W{1'b0}};
      end else if (s5_exp_q >= EXP_ONES) begin
        res_d = {s5_sign_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        ovf_d = 1'b1;
      end else if (s5_exp_q <= EXP_ZERO) begin
        res_d = {s5_sign_q, {(DATA_W-1){1'b0}}};
        unf_d = 1'b1;
      end else begin
        res_d = {s5_sign_q, s5_exp_q[EXP_W-1:0], s5_frac_q};
      end
    end else begin
      done_d = 1'b0;
      res_d  = res_q;
    end
    exc_d = ovf_d | unf_d | inv_d;
  end

  // Pipeline registers; reset drops every in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0; s1_byp_q <= {BYP_W{1'b0}}; s1_sign_q <= 1'b0; s1_esub_q <= 1'b0;
      s1_exp_big_q <= {EXP_W{1'b0}}; s1_exp_sml_q <= {EXP_W{1'b0}};
      s1_sig_big_q <= {SIG_W{1'b0}}; s1_sig_sml_q <= {SIG_W{1'b0}};
      s2_vld_q <= 1'b0; s2_byp_q <= {BYP_W{1'b0}}; s2_sign_q <= 1'b0; s2_esub_q <= 1'b0;
      s2_exp_q <= {EXP_W{1'b0}}; s2_sig_q <= {SIG_W{1'b0}}; s2_bal_q <= {EXT_W{1'b0}};
      s3_vld_q <= 1'b0; s3_byp_q <= {BYP_W{1'b0}}; s3_sign_q <= 1'b0;
      s3_exp_q <= {EXP_W{1'b0}}; s3_sum_q <= {(EXT_W+1){1'b0}};
      s4_vld_q <= 1'b0; s4_byp_q <= {BYP_W{1'b0}}; s4_sign_q <= 1'b0; s4_zero_q <= 1'b0;
      s4_exp_q <= {EW{1'b0}}; s4_man_q <= {SIG_W{1'b0}}; s4_grs_q <= 3'b000;
      s5_vld_q <= 1'b0; s5_byp_q <= {BYP_W{1'b0}}; s5_sign_q <= 1'b0; s5_zero_q <= 1'b0;
      s5_exp_q <= {EW{1'b0}}; s5_frac_q <= {FRAC_W{1'b0}};
    end else begin
      s1_vld_q <= s1_vld_d; s1_byp_q <= s1_byp_d; s1_sign_q <= s1_sign_d; s1_esub_q <= s1_esub_d;
      s1_exp_big_q <= s1_exp_big_d; s1_exp_sml_q <= s1_exp_sml_d;
      s1_sig_big_q <= s1_sig_big_d; s1_sig_sml_q <= s1_sig_sml_d;
      s2_vld_q <= s2_vld_d; s2_byp_q <= s2_byp_d; s2_sign_q <= s2_sign_d; s2_esub_q <= s2_esub_d;
      s2_exp_q <= s2_exp_d; s2_sig_q <= s2_sig_d; s2_bal_q <= s2_bal_d;
      s3_vld_q <= s3_vld_d; s3_byp_q <= s3_byp_d; s3_sign_q <= s3_sign_d;
      s3_exp_q <= s3_exp_d; s3_sum_q <= s3_sum_d;
      s4_vld_q <= s4_vld_d; s4_byp_q <= s4_byp_d; s4_sign_q <= s4_sign_d; s4_zero_q <= s4_zero_d;
      s4_exp_q <= s4_exp_d; s4_man_q <= s4_man_d; s4_grs_q <= s4_grs_d;
      s5_vld_q <= s5_vld_d; s5_byp_q <= s5_byp_d; s5_sign_q <= s5_sign_d; s5_zero_q <= s5_zero_d;
      s5_exp_q <= s5_exp_d; s5_frac_q <= s5_frac_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_q <= 1'b0; res_q <= {DATA_W{1'b0}};
      ovf_q <= 1'b0; unf_q <= 1'b0; inv_q <= 1'b0; exc_q <= 1'b0;
    end else begin
      done_q <= done_d; res_q <= res_d;
      ovf_q <= ovf_d; unf_q <= unf_d; inv_q <= inv_d; exc_q <= exc_d;
    end
  end

  assign done      = done_q;
  assign res       = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;
  assign exception = exc_q;
endmodule

// File: tb/tb_fp_addsub.sv
// Testbench for fp_addsub (32-bit format): directed table, streaming burst,
// randomized operands against an exact-arithmetic reference model, and a
// reset-while-busy sequence. A cycle-stamped scoreboard checks every cycle.
module tb_fp_addsub;
  logic        clk = 1'b0;
  logic        rst, start, sub;
  logic [31:0] op_a, op_b;
  logic        done, overflow, underflow, invalid, exception;
  logic [31:0] res;

  always #5 clk = ~clk;

  fp_addsub #(.DATA_W(32), .EXP_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .sub(sub), .op_a(op_a), .op_b(op_b),
    .done(done), .res(res), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .exception(exception)
  );

  typedef struct { logic s; logic [31:0] a, b, r; logic ov, un, iv; } vec_t;
  typedef struct { int cyc; logic [31:0] r; logic ov, un, iv; } exp_t;

  vec_t        tbl[17];
  exp_t        q[$];
  int          checks = 0, errors = 0, cyc = 0;
  logic [31:0] pend_r;
  logic        pend_ov, pend_un, pend_iv;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Significand of a normal number scaled by 2^60, shifted right by d, with
  // any lost bits folded into the lsb.
  function automatic logic [127:0] scale(input logic [22:0] f, input int d);
    logic [127:0] x, y;
    x = {105'd0, 1'b1, f} << 60;
    if (d > 80) return 128'd1;
    y = x >> d;
    if ((y << d) != x) y[0] = 1'b1;
    return y;
  endfunction

  // Reference: classify, then exact integer sum and a direct RNE of the result.
  function automatic void ref_model(input logic s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic ov, output logic un,
                                    output logic iv);
    logic sa, sb, rs;
    int ea, eb, e0, p, sh, e;
    logic [127:0] va, vb, mag, m, rem, half;
    sa = a[31]; sb = b[31] ^ s;
    ea = int'(a[30:23]); eb = int'(b[30:23]);
    ov = 1'b0; un = 1'b0; iv = 1'b0; r = 32'h0; rs = 1'b0;
    if ((ea == 255 && a[22:0] != 23'h0) || (eb == 255 && b[22:0] != 23'h0) ||
        (ea == 255 && eb == 255 && sa != sb)) begin
      r = 32'h7FC00000; iv = 1'b1;
    end else if (ea == 255) r = a;
    else if (eb == 255) r = {sb, b[30:0]};
    else if (ea == 0 && eb == 0) r = {sa & sb, 31'h0};
    else if (ea == 0) r = {sb, b[30:0]};
    else if (eb == 0) r = a;
    else begin
      e0 = (ea > eb) ? ea : eb;
      va = scale(a[22:0], e0 - ea);
      vb = scale(b[22:0], e0 - eb);
      if (sa == sb) begin mag = va + vb; rs = sa; end
      else if (va > vb) begin mag = va - vb; rs = sa; end
      else if (vb > va) begin mag = vb - va; rs = sb; end
      else mag = 128'd0;
      if (mag == 128'd0) r = 32'h0;
      else begin
        p = 0;
        for (int i = 0; i < 128; i++) if (mag[i]) p = i;
        sh   = p - 23;
        m    = mag >> sh;
        rem  = mag - (m << sh);
        half = 128'd1 << (sh - 1);
        e    = e0 + sh - 60;
        if (rem > half || (rem == half && m[0])) m = m + 128'd1;
        if (m[24]) begin m = m >> 1; e = e + 1; end
        if (e >= 255) begin r = {rs, 8'hFF, 23'h0}; ov = 1'b1; end
        else if (e <= 0) begin r = {rs, 31'h0}; un = 1'b1; end
        else r = {rs, e[7:0], m[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rnd_op(input int base);
    logic [31:0] w;
    int e, k;
    w = $urandom;
    k = int'($urandom_range(0, 19));
    case (k)
      0: e = 0;
      1: begin e = 255; w[22:0] = 23'h0; end
      2: e = 255;
      3: e = 254;
      4: e = 1;
      5: e = base;
      default: begin
        e = base + int'($urandom_range(0, 60)) - 30;
        if (e < 1) e = 1;
        if (e > 254) e = 254;
      end
    endcase
    w[30:23] = e[7:0];
    return w;
  endfunction

  task automatic issue_now(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] r, input logic ov, input logic un, input logic iv);
    start = 1'b1; sub = s; op_a = a; op_b = b;
    pend_r = r; pend_ov = ov; pend_un = un; pend_iv = iv;
  endtask

  task automatic issue(input vec_t v);
    @(negedge clk);
    issue_now(v.s, v.a, v.b, v.r, v.ov, v.un, v.iv);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  // Scoreboard: each accepted op must finish exactly 5 edges later.
  always begin
    exp_t e;
    @(posedge clk);
    cyc = cyc + 1;
    if (rst) q.delete();
    else if (start) q.push_back('{cyc, pend_r, pend_ov, pend_un, pend_iv});
    #1;
    if (rst) begin
      chk("reset_outputs", {26'h0, done, overflow, underflow, invalid, exception, |res}, 32'h0);
    end else if (q.size() > 0 && q[0].cyc == cyc - 5) begin
      e = q.pop_front();
      chk("done", {31'h0, done}, 32'h1);
      chk("res", res, e.r);
      chk("overflow", {31'h0, overflow}, {31'h0, e.ov});
      chk("underflow", {31'h0, underflow}, {31'h0, e.un});
      chk("invalid", {31'h0, invalid}, {31'h0, e.iv});
      chk("exception", {31'h0, exception}, {31'h0, e.ov | e.un | e.iv});
    end else begin
      chk("idle_done", {31'h0, done}, 32'h0);
      chk("idle_flags", {28'h0, overflow, underflow, invalid, exception}, 32'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t v;
    tbl[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h40400000, 32'h40000000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h00800001, 32'h00800000, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 32'h00000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 32'h80000000, 32'h00000000, 32'h80000000, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 1'b0, 1'b0, 1'b1};
    tbl[12] = '{1'b0, 32'h00000005, 32'h3F800000, 32'h3F800000, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'h3F800000, 32'hBF800000, 32'h00000000, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 32'hC0000000, 32'h3F800000, 32'hBF800000, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 32'h00FFFFFF, 32'h00800001, 32'h00000000, 1'b0, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = 32'h0; op_b = 32'h0;
    pend_r = 32'h0; pend_ov = 1'b0; pend_un = 1'b0; pend_iv = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Directed vectors, one at a time.
    for (int i = 0; i < 17; i++) begin
      issue(tbl[i]);
      idle(7);
    end

    // Ten back-to-back ops.
    for (int i = 0; i < 10; i++) issue(tbl[i]);
    idle(8);

    // Randomized ops with occasional gaps, near-cancellation included.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] t;
      int base;
      t = $urandom;
      base = int'($urandom_range(1, 254));
      v.s = t[9];
      v.a = rnd_op(base);
      if (t[12:10] == 3'd0) v.b = v.a ^ {t[0], 23'h0, t[8:1]};
      else v.b = rnd_op(base);
      ref_model(v.s, v.a, v.b, v.r, v.ov, v.un, v.iv);
      issue(v);
      if (t[14:13] == 2'd0) idle(int'($urandom_range(1, 3)));
    end
    idle(8);

    // Reset while three ops are in flight; none of them may complete.
    issue(tbl[0]); issue(tbl[5]); issue(tbl[7]);
    idle(1);
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    #1;
    chk("async_reset_done", {31'h0, done}, 32'h0);
    chk("async_reset_res", res, 32'h0);
    repeat (2) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    issue_now(tbl[4].s, tbl[4].a, tbl[4].b, tbl[4].r, tbl[4].ov, tbl[4].un, tbl[4].iv);
    idle(8);

    chk("drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
